// File: rtl/posted_write_responder_if.sv
// Store handshake and external SRAM write bus for posted_write_responder.
// master = write stage plus memory device side, slave = the responder.
interface posted_write_responder_if #(
   parameter int ADDR_W = 16
);
   logic              address_enable;
   logic [31:0]       address;
   logic [31:0]       data;
   logic              data_valid;
   logic [ADDR_W-1:0] mem_address;
   logic [31:0]       mem_data;
   logic              mem_write_n;
   logic              mem_ready;

   modport master (
      output address_enable, address, data, mem_ready,
      input  data_valid, mem_address, mem_data, mem_write_n
   );

   modport slave (
      input  address_enable, address, data, mem_ready,
      output data_valid, mem_address, mem_data, mem_write_n
   );
endinterface

// File: rtl/posted_write_responder.sv
// Posted-store FIFO drained to an asynchronous SRAM bus via a setup/strobe/recover FSM.
// Optional macro POSTED_WRITE_MERGE_EN folds a store into the newest queued entry on address match.
module posted_write_responder #(
   parameter int DEPTH       = 4,
   parameter int ADDR_W      = 16,
   parameter int WAIT_STATES = 2
) (
   input  logic                    clock,
   input  logic                    reset_n,
   posted_write_responder_if.slave bus,
   output logic                    drained,
   output logic [$clog2(DEPTH):0]  level
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_RECOVER
   } state_t;

   state_t            state_reg;
   logic [PTR_W-1:0]  wr_ptr_reg;
   logic [PTR_W-1:0]  rd_ptr_reg;
   logic [PTR_W-1:0]  wr_ptr_next;
   logic [PTR_W-1:0]  rd_ptr_next;
   logic [PTR_W-1:0]  newest_ptr;
   logic [3:0]        wait_cnt_reg;
   logic [ADDR_W-1:0] mem_address_reg;
   logic [31:0]       mem_data_reg;
   logic              mem_write_n_reg;

   logic [ADDR_W-1:0] fifo_addr [DEPTH];
   logic [31:0]       fifo_data [DEPTH];

   logic              empty;
   logic              full;
   logic              pop;
   logic              push;
   logic              merge_hit;
   logic              merge_write;
   logic              data_valid;
   logic [IDX_W-1:0]  wr_idx;
   logic [IDX_W-1:0]  load_idx;
   logic [IDX_W-1:0]  newest_idx;
   logic              load_from_incoming;
   logic              load_bypass_data;
   logic [ADDR_W-1:0] store_addr;
   logic [ADDR_W-1:0] load_addr;
   logic [31:0]       load_data;
   logic              unused_addr_bits;

   assign store_addr       = bus.address[ADDR_W-1:0];
   assign unused_addr_bits = ^bus.address[31:ADDR_W];

   assign empty      = (wr_ptr_reg == rd_ptr_reg);
   assign full       = (wr_ptr_reg[IDX_W] != rd_ptr_reg[IDX_W]) &&
                       (wr_ptr_reg[IDX_W-1:0] == rd_ptr_reg[IDX_W-1:0]);
   assign pop        = (state_reg == ST_RECOVER);
   assign newest_ptr = wr_ptr_reg - PTR_W'(1);
   assign newest_idx = newest_ptr[IDX_W-1:0];
   assign level      = wr_ptr_reg - rd_ptr_reg;
   assign drained    = empty && (state_reg == ST_IDLE);

`ifdef POSTED_WRITE_MERGE_EN
   // With a single entry outside IDLE, the newest entry is the one on the bus.
   logic newest_in_flight;
   assign newest_in_flight = (state_reg != ST_IDLE) && (level == PTR_W'(1));
   assign merge_hit = bus.address_enable && !empty && !newest_in_flight &&
                      (fifo_addr[newest_idx] == store_addr);
`else
   assign merge_hit = 1'b0;
`endif

   assign data_valid  = reset_n && bus.address_enable && (!full || pop || merge_hit);
   assign push        = data_valid && !merge_hit;
   assign merge_write = data_valid && merge_hit;

   assign wr_idx      = wr_ptr_reg[IDX_W-1:0];
   assign wr_ptr_next = wr_ptr_reg + PTR_W'(push);
   assign rd_ptr_next = rd_ptr_reg + PTR_W'(pop);

   // Next head may be written on the same edge it is loaded onto the bus.
   assign load_idx           = rd_ptr_next[IDX_W-1:0];
   assign load_from_incoming = push && (wr_ptr_reg == rd_ptr_next);
   assign load_bypass_data   = load_from_incoming || (merge_write && (newest_idx == load_idx));
   assign load_addr          = load_from_incoming ? store_addr : fifo_addr[load_idx];
   assign load_data          = load_bypass_data ? bus.data : fifo_data[load_idx];

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [ADDR_W-1:0] addr_reg;
         logic [31:0]       data_reg;

         always_ff @(posedge clock) begin
            if (push && (wr_idx == IDX_W'(gi))) begin
               addr_reg <= store_addr;
               data_reg <= bus.data;
            end else if (merge_write && (newest_idx == IDX_W'(gi))) begin
               data_reg <= bus.data;
            end
         end

         assign fifo_addr[gi] = addr_reg;
         assign fifo_data[gi] = data_reg;
      end
   endgenerate

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg       <= ST_IDLE;
         wr_ptr_reg      <= '0;
         rd_ptr_reg      <= '0;
         wait_cnt_reg    <= '0;
         mem_address_reg <= '0;
         mem_data_reg    <= '0;
         mem_write_n_reg <= 1'b1;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         case (state_reg)
            ST_IDLE: begin
               if (!empty || push) begin
                  state_reg       <= ST_SETUP;
                  mem_address_reg <= load_addr;
                  mem_data_reg    <= load_data;
               end
            end
            ST_SETUP: begin
               state_reg       <= ST_STROBE;
               mem_write_n_reg <= 1'b0;
               wait_cnt_reg    <= 4'(WAIT_STATES);
            end
            ST_STROBE: begin
               if (wait_cnt_reg == 4'd0) begin
                  if (bus.mem_ready) begin
                     state_reg       <= ST_RECOVER;
                     mem_write_n_reg <= 1'b1;
                  end
               end else begin
                  wait_cnt_reg <= wait_cnt_reg - 4'd1;
               end
            end
            ST_RECOVER: begin
               if (wr_ptr_next != rd_ptr_next) begin
                  state_reg       <= ST_SETUP;
                  mem_address_reg <= load_addr;
                  mem_data_reg    <= load_data;
               end else begin
                  state_reg <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign bus.data_valid  = data_valid;
   assign bus.mem_address = mem_address_reg;
   assign bus.mem_data    = mem_data_reg;
   assign bus.mem_write_n = mem_write_n_reg;
endmodule

// File: tb/tb_posted_write_responder.sv
// Directed bench for posted_write_responder: stores are queued as expected bus writes and
// checked in order when the strobe falls; follows POSTED_WRITE_MERGE_EN when defined.
module tb_posted_write_responder;
   localparam int DEPTH       = 4;
   localparam int ADDR_W      = 16;
   localparam int WAIT_STATES = 2;
`ifdef POSTED_WRITE_MERGE_EN
   localparam bit MERGE_EN = 1'b1;
`else
   localparam bit MERGE_EN = 1'b0;
`endif

   typedef struct {
      logic [15:0] a;
      logic [31:0] d;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       drained;
   logic [2:0] level;
   int         checks = 0;
   int         errors = 0;
   int         strobes = 0;
   exp_t       exp_q[$];

   posted_write_responder_if #(.ADDR_W(ADDR_W)) bus();

   posted_write_responder #(
      .DEPTH(DEPTH), .ADDR_W(ADDR_W), .WAIT_STATES(WAIT_STATES)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .bus(bus.slave),
      .drained(drained),
      .level(level)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Drive a store and hold it until accepted (bounded); record the expected bus write.
   task automatic accept(input logic [31:0] a, input logic [31:0] d, input logic [15:0] ea,
                         input bit merge, input string tag, output int stalls);
      exp_t e;
      int   n = 0;
      bus.address_enable = 1'b1;
      bus.address        = a;
      bus.data           = d;
      #1;
      while (bus.data_valid !== 1'b1 && n < 60) begin
         @(posedge clock);
         #2;
         n++;
      end
      check({tag, "_accept"}, 64'(bus.data_valid), 64'd1);
      if (bus.data_valid === 1'b1) begin
         if (merge && exp_q.size() > 0) begin
            e   = exp_q.pop_back();
            e.d = d;
            exp_q.push_back(e);
         end else begin
            e.a = ea;
            e.d = d;
            exp_q.push_back(e);
         end
         $display("store %s addr=0x%08h data=0x%08h stalls=%0d", tag, a, d, n);
      end
      stalls = n;
      tick();
   endtask

   task automatic wait_strobe(input string tag);
      int n = 0;
      while (bus.mem_write_n !== 1'b0 && n < 60) begin
         tick();
         n++;
      end
      check({tag, "_strobe"}, 64'(bus.mem_write_n), 64'd0);
   endtask

   task automatic wait_drained(input string tag);
      int n = 0;
      while (drained !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      check({tag, "_drained"}, 64'(drained), 64'd1);
   endtask

   // Bus monitor: every falling strobe must match the oldest outstanding store.
   initial begin : monitor
      logic prev_wn;
      exp_t e;
      prev_wn = 1'b1;
      forever begin
         @(negedge clock);
         if (reset_n && prev_wn && !bus.mem_write_n) begin
            strobes++;
            $display("bus write %0d addr=0x%04h data=0x%08h", strobes, bus.mem_address, bus.mem_data);
            if (exp_q.size() == 0) begin
               check("sb_underflow", 64'(exp_q.size()), 64'd1);
            end else begin
               e = exp_q.pop_front();
               check("sb_addr", 64'(bus.mem_address), 64'(e.a));
               check("sb_data", 64'(bus.mem_data), 64'(e.d));
            end
         end
         prev_wn = reset_n ? bus.mem_write_n : 1'b1;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int st;
      int base;
      logic [0:5] wn_pat;
      logic [0:5] dr_pat;
      logic [0:5] lv_pat;

      bus.address_enable = 1'b1;
      bus.address        = 32'h0000_0010;
      bus.data           = 32'h0000_0001;
      bus.mem_ready      = 1'b0;

      // Reset state
      repeat (2) @(posedge clock);
      #1;
      check("rst_data_valid", 64'(bus.data_valid), 64'd0);
      check("rst_write_n", 64'(bus.mem_write_n), 64'd1);
      check("rst_mem_address", 64'(bus.mem_address), 64'd0);
      check("rst_mem_data", 64'(bus.mem_data), 64'd0);
      check("rst_level", 64'(level), 64'd0);
      check("rst_drained", 64'(drained), 64'd1);
      bus.address_enable = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      tick();

      // Single store: SETUP, 3 STROBE, RECOVER, then drained
      bus.mem_ready = 1'b1;
      base = strobes;
      accept(32'h0000_0010, 32'hDEAD_BEEF, 16'h0010, 1'b0, "single", st);
      bus.address_enable = 1'b0;
      check("single_zero_latency", 64'(st), 64'd0);
      check("single_setup_addr", 64'(bus.mem_address), 64'h0010);
      check("single_setup_data", 64'(bus.mem_data), 64'hDEAD_BEEF);
      wn_pat = 6'b100011;
      dr_pat = 6'b000001;
      lv_pat = 6'b111110;
      for (int k = 0; k < 6; k++) begin
         check("single_write_n", 64'(bus.mem_write_n), 64'(wn_pat[k]));
         check("single_drained", 64'(drained), 64'(dr_pat[k]));
         check("single_level", 64'(level), 64'(lv_pat[k]));
         if (k < 5) tick();
      end
      check("single_strobes", 64'(strobes - base), 64'd1);

      // Burst of 6 with the device stalled: only 4 fit
      bus.mem_ready = 1'b0;
      base = strobes;
      for (int i = 0; i < 4; i++) begin
         accept(32'h0000_0100 + 32'(i), 32'hB000_0000 + 32'(i), 16'h0100 + 16'(i), 1'b0, "burst", st);
         check("burst_zero_latency", 64'(st), 64'd0);
      end
      bus.address_enable = 1'b1;
      bus.address        = 32'h0000_0104;
      bus.data           = 32'hB000_0004;
      #1;
      check("burst_full_level", 64'(level), 64'd4);
      check("burst_full_reject", 64'(bus.data_valid), 64'd0);
      repeat (3) begin
         @(posedge clock);
         #2;
         check("burst_hold_reject", 64'(bus.data_valid), 64'd0);
      end
      bus.mem_ready = 1'b1;
      @(posedge clock);
      #2;
      check("burst_recover_accept", 64'(bus.data_valid), 64'd1);
      check("burst_recover_write_n", 64'(bus.mem_write_n), 64'd1);
      check("burst_recover_level", 64'(level), 64'd4);
      if (bus.data_valid === 1'b1) begin
         exp_q.push_back('{a: 16'h0104, d: 32'hB000_0004});
         $display("store burst addr=0x00000104 data=0xb0000004 stalls=4");
      end
      tick();
      check("burst_push_pop_level", 64'(level), 64'd4);
      accept(32'h0000_0105, 32'hB000_0005, 16'h0105, 1'b0, "burst6", st);
      bus.address_enable = 1'b0;
      wait_drained("burst");
      check("burst_strobes", 64'(strobes - base), 64'd6);

      // Device holds mem_ready low for 10 strobe cycles
      bus.mem_ready = 1'b0;
      accept(32'h0000_1234, 32'hCAFE_F00D, 16'h1234, 1'b0, "stall", st);
      bus.address_enable = 1'b0;
      wait_strobe("stall");
      for (int k = 0; k < 10; k++) begin
         tick();
         check("stall_write_n", 64'(bus.mem_write_n), 64'd0);
         check("stall_addr", 64'(bus.mem_address), 64'h1234);
         check("stall_data", 64'(bus.mem_data), 64'hCAFE_F00D);
      end
      bus.mem_ready = 1'b1;
      tick();
      check("stall_done_write_n", 64'(bus.mem_write_n), 64'd1);
      wait_drained("stall");

      // Upper address bits are dropped
      accept(32'h0001_0020, 32'h5A5A_A5A5, 16'h0020, 1'b0, "trunc", st);
      bus.address_enable = 1'b0;
      wait_drained("trunc");

      // Reset mid-STROBE with three stores queued
      bus.mem_ready = 1'b0;
      accept(32'h0000_0200, 32'h1000_0000, 16'h0200, 1'b0, "rst_a", st);
      accept(32'h0000_0201, 32'h1000_0001, 16'h0201, 1'b0, "rst_b", st);
      accept(32'h0000_0202, 32'h1000_0002, 16'h0202, 1'b0, "rst_c", st);
      bus.address_enable = 1'b0;
      wait_strobe("rst");
      check("rst_mid_level", 64'(level), 64'd3);
      #2;
      reset_n = 1'b0;
      #1;
      check("rst_async_write_n", 64'(bus.mem_write_n), 64'd1);
      exp_q.delete();
      base = strobes;
      @(negedge clock);
      reset_n = 1'b1;
      bus.mem_ready = 1'b1;
      tick();
      check("rst_after_level", 64'(level), 64'd0);
      check("rst_after_drained", 64'(drained), 64'd1);
      check("rst_after_write_n", 64'(bus.mem_write_n), 64'd1);
      repeat (8) tick();
      check("rst_no_strobes", 64'(strobes - base), 64'd0);

      // Same-address stores behind a busy head
      bus.mem_ready = 1'b0;
      base = strobes;
      accept(32'h0000_0030, 32'h0000_AAAA, 16'h0030, 1'b0, "merge_head", st);
      bus.address_enable = 1'b0;
      wait_strobe("merge");
      accept(32'h0000_0040, 32'h0000_1111, 16'h0040, 1'b0, "merge_first", st);
      accept(32'h0000_0040, 32'h0000_2222, 16'h0040, MERGE_EN, "merge_second", st);
      bus.address_enable = 1'b0;
      check("merge_level", 64'(level), MERGE_EN ? 64'd2 : 64'd3);
      bus.mem_ready = 1'b1;
      wait_drained("merge");
      check("merge_strobes", 64'(strobes - base), MERGE_EN ? 64'd2 : 64'd3);

      tick();
      check("sb_empty", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
